// File: rtl/pipeline_pkg.sv
// Shared constants for the pipeline stall/flush controller.
//   - stage indices into the stall vector (PC..WB)
//   - stall encodings, one per requesting stage (higher stage wins)
//   - memory wait FSM state encoding
package pipeline_pkg;

  localparam int unsigned STG_PC  = 0;
  localparam int unsigned STG_IF  = 1;
  localparam int unsigned STG_ID  = 2;
  localparam int unsigned STG_EX  = 3;
  localparam int unsigned STG_MEM = 4;
  localparam int unsigned STG_WB  = 5;
  localparam int unsigned NUM_STAGES = STG_WB + 1;

  localparam logic [NUM_STAGES-1:0] STALL_NONE = 6'b000000;
  localparam logic [NUM_STAGES-1:0] STALL_IF   = 6'b000011;
  localparam logic [NUM_STAGES-1:0] STALL_ID   = 6'b000111;
  localparam logic [NUM_STAGES-1:0] STALL_EX   = 6'b001111;
  localparam logic [NUM_STAGES-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait-state sequencer.
//   clk, rst   : clock, synchronous active-high reset
//   mem_req    : MEM stage issues an access
//   mem_ack    : memory completes the access
//   mem_stall  : hold MEM and everything upstream this cycle
//   mem_err    : one-cycle pulse when the wait exceeds MEM_TIMEOUT
module mem_wait_fsm
  import pipeline_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic mem_req,
  input  logic mem_ack,
  output logic mem_stall,
  output logic mem_err
);

  localparam logic [7:0] MT_LIMIT = 8'(MEM_TIMEOUT);

  mem_state_t state, state_nx;
  logic [7:0] mt, mt_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= M_IDLE;
      mt    <= '0;
    end else begin
      state <= state_nx;
      mt    <= mt_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    mt_nx     = mt;
    mem_stall = 1'b0;
    mem_err   = 1'b0;
    case (state)
      M_IDLE: begin
        // An access acked in the same cycle needs no wait state.
        if (mem_req && !mem_ack) begin
          mem_stall = 1'b1;
          state_nx  = M_WAIT;
          mt_nx     = 8'd1;
        end
      end
      M_WAIT: begin
        if (mem_ack) begin
          state_nx = M_IDLE;
          mt_nx    = '0;
        end else if (mt == MT_LIMIT) begin
          // Give up: release the pipeline and flag the error instead.
          mem_err  = 1'b1;
          state_nx = M_IDLE;
          mt_nx    = '0;
        end else begin
          mem_stall = 1'b1;
          mt_nx     = mt + 8'd1;
        end
      end
      default: begin
        state_nx = M_IDLE;
        mt_nx    = '0;
      end
    endcase
    if (rst) begin
      mem_stall = 1'b0;
      mem_err   = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller for the six-stage pipeline.
//   clk, rst      : clock, synchronous active-high reset
//   if_stall_req  : fetch not ready
//   id_stall_req  : load-use hazard
//   ex_mc_start   : EX begins a multi-cycle op
//   mem_req/ack   : data-memory access handshake
//   branch_flush  : ID resolved a taken branch
//   stall[5:0]    : hold per stage (bit0 PC .. bit5 WB)
//   flush         : clear IF_ID this cycle
//   ex_mc_busy    : multi-cycle unit occupied
//   ex_mc_done    : final cycle of the multi-cycle op
//   mem_err       : memory timeout pulse
//   stall_cycles  : saturating count of cycles with the PC held
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int unsigned MC_CYCLES   = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_stall_req,
  input  logic                  id_stall_req,
  input  logic                  ex_mc_start,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  input  logic                  branch_flush,
  output logic [NUM_STAGES-1:0] stall,
  output logic                  flush,
  output logic                  ex_mc_busy,
  output logic                  ex_mc_done,
  output logic                  mem_err,
  output logic [31:0]           stall_cycles
);

  localparam logic [7:0] MC_LOAD = 8'(MC_CYCLES - 1);

  logic [7:0]  mc_cnt;
  logic        mc_idle;
  logic        mc_launch;
  logic        mem_stall;
  logic        flush_pend;
  logic [31:0] sc_q;

  mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_stall (mem_stall),
    .mem_err   (mem_err)
  );

  assign mc_idle   = (mc_cnt == '0);
  assign mc_launch = ex_mc_start && mc_idle;

  // The launch cycle itself counts as busy, so the timer only needs
  // MC_CYCLES-1 further cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      mc_cnt <= '0;
    end else if (mc_launch) begin
      mc_cnt <= MC_LOAD;
    end else if (!mc_idle) begin
      mc_cnt <= mc_cnt - 8'd1;
    end
  end

  always_comb begin
    ex_mc_busy = 1'b0;
    ex_mc_done = 1'b0;
    stall      = STALL_NONE;
    flush      = 1'b0;
    if (!rst) begin
      ex_mc_busy = mc_launch || !mc_idle;
      ex_mc_done = (mc_cnt == 8'd1);
      if (mem_stall) begin
        stall = STALL_MEM;
      end else if (ex_mc_busy) begin
        stall = STALL_EX;
      end else if (id_stall_req) begin
        stall = STALL_ID;
      end else if (if_stall_req) begin
        stall = STALL_IF;
      end
      // A held ID stage cannot take the flush; keep it pending instead.
      flush = (flush_pend || branch_flush) && !stall[STG_ID];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pend <= 1'b0;
    end else if (flush) begin
      flush_pend <= 1'b0;
    end else if (branch_flush) begin
      flush_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sc_q <= '0;
    end else if (stall[STG_PC] && (sc_q != '1)) begin
      sc_q <= sc_q + 32'd1;
    end
  end

  assign stall_cycles = rst ? '0 : sc_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;
  import pipeline_pkg::*;

  logic        clk;
  logic        rst;
  logic        if_stall_req;
  logic        id_stall_req;
  logic        ex_mc_start;
  logic        mem_req;
  logic        mem_ack;
  logic        branch_flush;
  logic [5:0]  stall;
  logic        flush;
  logic        ex_mc_busy;
  logic        ex_mc_done;
  logic        mem_err;
  logic [31:0] stall_cycles;

  int unsigned n_tests;
  int unsigned n_fail;

  pipeline_ctrl #(
    .MC_CYCLES  (4),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_stall_req(if_stall_req),
    .id_stall_req(id_stall_req),
    .ex_mc_start (ex_mc_start),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .branch_flush(branch_flush),
    .stall       (stall),
    .flush       (flush),
    .ex_mc_busy  (ex_mc_busy),
    .ex_mc_done  (ex_mc_done),
    .mem_err     (mem_err),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the posedge; combinational outputs are
  // sampled 2 units later, well before the next edge.
  task automatic drive(input logic r, input logic ifs, input logic ids, input logic mc,
                       input logic req, input logic ack, input logic bf);
    rst = r; if_stall_req = ifs; id_stall_req = ids; ex_mc_start = mc;
    mem_req = req; mem_ack = ack; branch_flush = bf;
    #2;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_cyc(input string tag, input logic [5:0] e_stall, input logic e_flush,
                           input logic e_busy, input logic e_done, input logic e_err);
    check({tag, ".stall"}, 32'(stall), 32'(e_stall));
    check({tag, ".flush"}, 32'(flush), 32'(e_flush));
    check({tag, ".busy"},  32'(ex_mc_busy), 32'(e_busy));
    check({tag, ".done"},  32'(ex_mc_done), 32'(e_done));
    check({tag, ".err"},   32'(mem_err), 32'(e_err));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset
    drive(1, 0, 0, 0, 0, 0, 0);
    check_cyc("rst", STALL_NONE, 0, 0, 0, 0);
    tick;
    drive(1, 0, 0, 0, 0, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cyc("idle", STALL_NONE, 0, 0, 0, 0);
    check("sc_reset", stall_cycles, 32'd0);
    tick;

    // ID hazard for one cycle
    drive(0, 0, 1, 0, 0, 0, 0);
    check_cyc("id0", 6'b000111, 0, 0, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cyc("id1", 6'b000000, 0, 0, 0, 0);
    check("sc_id", stall_cycles, 32'd1);
    tick;

    // IF wait
    drive(0, 1, 0, 0, 0, 0, 0);
    check_cyc("if0", 6'b000011, 0, 0, 0, 0);
    tick;   // sc = 2

    // Multi-cycle EX op, second start at t+1 ignored
    drive(0, 0, 0, 1, 0, 0, 0);
    check_cyc("ex0", 6'b001111, 0, 1, 0, 0);
    tick;
    drive(0, 0, 0, 1, 0, 0, 0);
    check_cyc("ex1", 6'b001111, 0, 1, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cyc("ex2", 6'b001111, 0, 1, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cyc("ex3", 6'b001111, 0, 1, 1, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cyc("ex4", 6'b000000, 0, 0, 0, 0);
    check("sc_ex", stall_cycles, 32'd6);
    tick;

    // MEM access, ack three cycles after the request
    drive(0, 0, 0, 0, 1, 0, 0);
    check_cyc("mw0", 6'b011111, 0, 0, 0, 0);
    tick;
    drive(0, 0, 0, 0, 1, 0, 0);
    check_cyc("mw1", 6'b011111, 0, 0, 0, 0);
    tick;
    drive(0, 0, 0, 0, 1, 0, 0);
    check_cyc("mw2", 6'b011111, 0, 0, 0, 0);
    tick;
    drive(0, 0, 0, 0, 1, 1, 0);
    check_cyc("mw3", 6'b000000, 0, 0, 0, 0);
    tick;
    // zero-wait access
    drive(0, 0, 0, 0, 1, 1, 0);
    check_cyc("mz0", 6'b000000, 0, 0, 0, 0);
    check("sc_mem", stall_cycles, 32'd9);
    tick;

    // MEM timeout (limit 4)
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 0, 0);
      check_cyc($sformatf("mt%0d", i), 6'b011111, 0, 0, 0, 0);
      tick;
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    check_cyc("mt4", 6'b000000, 0, 0, 0, 1);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cyc("mt5", 6'b000000, 0, 0, 0, 0);
    check("sc_mt", stall_cycles, 32'd13);
    tick;

    // MEM and EX together: EX timer advances under the MEM stall
    drive(0, 0, 0, 1, 1, 0, 0);
    check_cyc("pr0", 6'b011111, 0, 1, 0, 0);
    tick;
    drive(0, 0, 0, 0, 1, 0, 0);
    check_cyc("pr1", 6'b011111, 0, 1, 0, 0);
    tick;
    drive(0, 0, 0, 0, 1, 1, 0);
    check_cyc("pr2", 6'b001111, 0, 1, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cyc("pr3", 6'b001111, 0, 1, 1, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cyc("pr4", 6'b000000, 0, 0, 0, 0);
    tick;

    // Unstalled branch flush: immediate, single cycle
    drive(0, 0, 0, 0, 0, 0, 1);
    check_cyc("fl0", 6'b000000, 1, 0, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cyc("fl1", 6'b000000, 0, 0, 0, 0);
    tick;

    // Branch flush during EX stall, repeated request merges
    drive(0, 0, 0, 1, 0, 0, 1);
    check_cyc("fe0", 6'b001111, 0, 1, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 1);
    check_cyc("fe1", 6'b001111, 0, 1, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cyc("fe2", 6'b001111, 0, 1, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cyc("fe3", 6'b001111, 0, 1, 1, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cyc("fe4", 6'b000000, 1, 0, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cyc("fe5", 6'b000000, 0, 0, 0, 0);
    tick;

    // Flush held by an ID hazard
    drive(0, 0, 1, 0, 0, 0, 1);
    check_cyc("fi0", 6'b000111, 0, 0, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    check_cyc("fi1", 6'b000000, 1, 0, 0, 0);
    tick;

    // Reset in the middle of an EX op and a memory wait, flush pending
    drive(0, 0, 0, 1, 0, 0, 1);
    check_cyc("rm0", 6'b001111, 0, 1, 0, 0);
    tick;
    drive(0, 0, 0, 0, 1, 0, 0);
    check_cyc("rm1", 6'b011111, 0, 1, 0, 0);
    tick;
    drive(1, 0, 0, 0, 0, 0, 0);
    check_cyc("rm2", 6'b000000, 0, 0, 0, 0);
    check("sc_rm2", stall_cycles, 32'd0);
    tick;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      check_cyc($sformatf("ra%0d", i), 6'b000000, 0, 0, 0, 0);
      check($sformatf("sc_ra%0d", i), stall_cycles, 32'd0);
      tick;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the six-stage pipeline (PC, IF, ID, EX, MEM, WB). It merges stall requests from IF, ID, EX and MEM into the `stall[5:0]` vector sampled by every inter-stage register (PC, IF_ID, ID_EX, EX_MEM, MEM_WB). It sequences multi-cycle EX operations and data-memory wait states, defers branch flushes until ID can accept them, and counts stalled cycles.

## Interface
- `MC_CYCLES`, 32, total EX stall cycles per multi-cycle op (≥2)
- `MEM_TIMEOUT`, 255, max M_WAIT cycles before forced release (≥2, ≤255)
- `clk` input 1 single clock; all state updates on posedge
- `rst` input 1 synchronous, active-high reset
- `if_stall_req` input 1 fetch not ready this cycle
- `id_stall_req` input 1 load-use hazard this cycle
- `ex_mc_start` input 1 EX begins a multi-cycle op (div/mul)
- `mem_req` input 1 MEM stage issues a data-memory access
- `mem_ack` input 1 data memory completes the access
- `branch_flush` input 1 ID resolved a taken branch
- `stall` output 6 bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = hold
- `flush` output 1 clear IF_ID this cycle
- `ex_mc_busy` output 1 multi-cycle unit occupied
- `ex_mc_done` output 1 final cycle of the multi-cycle op
- `mem_err` output 1 one-cycle pulse on memory timeout
- `stall_cycles` output 32 saturating count of cycles with `stall[0]`=1

## Operation
- Stall encoding, highest stage wins: MEM wait 6'b011111; EX busy 6'b001111; ID hazard 6'b000111; IF wait 6'b000011; none 6'b000000.
- Bubble rule for registers: `stall[i]`=1 with `stall[i+1]`=0 inserts a bubble downstream; `stall` never has a 1 above a 0.
- Multi-cycle timer: `mc_cnt` (8 bit). When `ex_mc_start` and `mc_cnt`==0: `mc_cnt`<=MC_CYCLES-1. Otherwise, when `mc_cnt`!=0, decrement.
  - `ex_mc_busy` = (`ex_mc_start` & `mc_cnt`==0) | (`mc_cnt`!=0).
  - `ex_mc_done` = (`mc_cnt`==1).
  - `ex_mc_start` while `mc_cnt`!=0 is ignored.
- Memory FSM, states M_IDLE and M_WAIT, with 8-bit wait timer `mt`:
  - M_IDLE, `mem_req` & `mem_ack`: zero-wait access, no stall.
  - M_IDLE, `mem_req` & !`mem_ack`: MEM stall; go to M_WAIT; `mt`<=1.
  - M_WAIT, !`mem_ack`: stall; `mt`++.
  - M_WAIT, `mem_ack`: no stall this cycle; go to M_IDLE.
  - M_WAIT, `mt`==MEM_TIMEOUT & !`mem_ack`: no stall; `mem_err`=1; go to M_IDLE.
- Flush: `branch_flush` sets `flush_pend`. `flush` = (`flush_pend` | `branch_flush`) & !`stall[2]`. `flush_pend` clears in the cycle `flush` is asserted. A repeated request while pending merges into the one pending flush.
- `stall_cycles`: +1 per cycle with `stall[0]`=1; holds at 32'hFFFF_FFFF.

## Timing
- `stall`, `flush`, `ex_mc_busy`, `ex_mc_done` and `mem_err` are combinational from inputs and state in the same cycle. Pipeline registers act on them at the next posedge.
- EX op started in cycle t: `stall[3]`=1 in cycles t..t+MC_CYCLES-1; `ex_mc_done` in cycle t+MC_CYCLES-1; released in cycle t+MC_CYCLES.
- MEM access with ack k cycles after `mem_req`: stalled for exactly k cycles.
- Simultaneous requests: encoding priority applies. Lower-stage state still advances (the EX timer keeps counting under a MEM stall).
- While `rst`=1: all outputs are 0. Next state: M_IDLE, `mc_cnt`=0, `mt`=0, `flush_pend`=0, `stall_cycles`=0. Reset mid-operation abandons the op with no `ex_mc_done` or `mem_err`.

## Structure
- Package `pipeline_pkg` holds:
  - stall constants STALL_NONE, STALL_IF, STALL_ID, STALL_EX, STALL_MEM;
  - stage index constants;
  - memory FSM state encoding (M_IDLE, M_WAIT).
- Sub-module `mem_wait_fsm` holds the memory FSM and timer, with outputs `mem_stall` and `mem_err`. The top level holds the EX timer, flush logic, priority encode and counter.

## Test plan
- Reset, then `id_stall_req`=1 for one cycle -> `stall`=6'b000111 that cycle only, then 0; `stall_cycles`=1.
- MC_CYCLES=4, `ex_mc_start` at t -> `stall`=6'b001111 in t..t+3; `ex_mc_done` at t+3; second start at t+1 ignored.
- `mem_req` at t, `mem_ack` at t+3 -> `stall`=6'b011111 in t..t+2, 0 at t+3. `mem_req` with `mem_ack` at t -> no stall.
- MEM_TIMEOUT=4, `mem_req` with no ack -> stalled t..t+3, `mem_err` and release at t+4.
- `branch_flush` during an EX stall -> `flush`=0 until `stall[2]` drops, then `flush`=1 for exactly one cycle.
- `rst` asserted mid EX op and mid M_WAIT -> next cycle all outputs 0, `stall_cycles`=0, no done or error pulse.
